// File: rtl/fsm_io_pkg.sv
// Shared constants and helpers for the board-input blocks.
// Exports CLK_HZ, default debounce/repeat periods and cnt_width().
package fsm_io_pkg;

    localparam int CLK_HZ = 100_000_000;

    // 10 ms debounce window at CLK_HZ
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    // 0.5 s auto-repeat period at CLK_HZ
    localparam int DEFAULT_REPEAT_CYCLES = 50_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain followed by a debouncer.
// Ports: clk, reset (async, active-low), din (raw), dout (stable level),
// rise (one-cycle pulse on the edge where dout goes 0->1).
module debounce_channel
    import fsm_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Any cycle of agreement restarts the window, so bounces never
    // accumulate toward a change.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = synced;
            cnt_d    = '0;
            rise_d   = synced;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign dout = stable_q;
    assign rise = rise_q;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Board-input front end: debounced switch level w and step pulse.
// Ports: clk, reset (async, active-low), w_raw, step_raw, w, step.
// Optional macro FSM_STEP_AUTOREPEAT_EN: step repeats while held.
module fsm_input_conditioner
    import fsm_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic w_raw,
    input  logic step_raw,
    output logic w,
    output logic step
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_chk_rep
        $error("REPEAT_CYCLES must be >= 2");
    end

    logic btn_level;
    logic btn_rise;
    logic w_rise;

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clk   (clk),
        .reset (reset),
        .din   (w_raw),
        .dout  (w),
        .rise  (w_rise)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .din   (step_raw),
        .dout  (btn_level),
        .rise  (btn_rise)
    );

`ifdef FSM_STEP_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          fire_q, fire_d;

    // Counter sits at 0 while released; it starts counting on the
    // edge after the press pulse, so the first repeat lands exactly
    // REPEAT_CYCLES edges after it.
    always_comb begin
        rep_d  = rep_q;
        fire_d = 1'b0;
        if (!btn_level) begin
            rep_d = '0;
        end else if (rep_q == REP_MAX) begin
            rep_d  = '0;
            fire_d = 1'b1;
        end else begin
            rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            fire_q <= fire_d;
        end
    end

    assign step = btn_rise | fire_q;
`else
    assign step = btn_rise;
`endif

endmodule
